// File: rtl/pingpong_pkg.sv
// rtl/pingpong_pkg.sv - shared types and widths for the ping-pong nibble buffer
package pingpong_pkg;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} pp_state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/mux2.sv
// rtl/mux2.sv - 4-bit 2:1 mux selecting d1 when s is high
module mux2
  import pingpong_pkg::*;
(
  input  logic [NIBBLE_W-1:0] d0,
  input  logic [NIBBLE_W-1:0] d1,
  input  logic                s,
  output logic [NIBBLE_W-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/pingpong_buf4.sv
// rtl/pingpong_buf4.sv - two-bank 4-bit elastic stage feeding mux2
module pingpong_buf4
  import pingpong_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NIBBLE_W-1:0] out_data,
  output logic [1:0]          level
);

  pp_state_t           r_state;
  logic [NIBBLE_W-1:0] r_bank0;
  logic [NIBBLE_W-1:0] r_bank1;
  logic                r_wr_sel;
  logic                r_rd_sel;

  logic                w_push;
  logic                w_pop;

  // Handshake outputs come from the registered state only, so out_ready
  // can never reach in_ready combinationally.
  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign level     = (r_state == FULL) ? 2'd2 :
                     (r_state == ONE)  ? 2'd1 : 2'd0;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // Banks, bank selects and occupancy FSM; reset wins over push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= EMPTY;
      r_bank0  <= '0;
      r_bank1  <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      if (w_push) begin
        if (r_wr_sel) begin
          r_bank1 <= in_data;
        end else begin
          r_bank0 <= in_data;
        end
        r_wr_sel <= ~r_wr_sel;
      end

      if (w_pop) begin
        r_rd_sel <= ~r_rd_sel;
      end

      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_push && !w_pop) begin
            r_state <= FULL;
          end else if (w_pop && !w_push) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // The oldest entry is presented through the existing 2:1 mux.
  mux2 u_mux2 (
    .d0 (r_bank0),
    .d1 (r_bank1),
    .s  (r_rd_sel),
    .y  (out_data)
  );

endmodule

// File: doc/pingpong_buf4.md
# pingpong_buf4

Two-entry, 4-bit ping-pong buffer with valid/ready handshakes on both sides. Incoming nibbles are written alternately into bank 0 and bank 1. The stored banks plus a read-select bit drive the existing 4-bit 2:1 mux (`mux2`), which produces the output nibble. The block is the stage directly upstream of `mux2`: it generates that mux's `d0`, `d1` and `s`, and turns the bare mux into a flow-controlled elastic stage.

## Interface
- Parameters: none. Width is fixed at 4 bits to match `mux2`.
- Reset is synchronous and active-high.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `reset` in 1 — synchronous, active-high; clears all state.
- `in_valid` in 1 — producer has a nibble on `in_data`.
- `in_ready` out 1 — buffer can accept; a transfer occurs when `in_valid & in_ready` at a rising edge.
- `in_data` in 4 — write data.
- `out_valid` out 1 — `out_data` holds the oldest stored nibble.
- `out_ready` in 1 — consumer accepts; a transfer occurs when `out_valid & out_ready` at a rising edge.
- `out_data` out 4 — oldest nibble, selected combinationally through `mux2`.
- `level` out 2 — occupancy: 0, 1 or 2.

## Operation
- State registers:
  - `bank0[3:0]` and `bank1[3:0]`.
  - `wr_sel` (1 bit): the bank for the next write.
  - `rd_sel` (1 bit): the bank holding the oldest entry.
  - FSM `state` ∈ {EMPTY, ONE, FULL}.
- Derived signals:
  - `push = in_valid & in_ready`
  - `pop = out_valid & out_ready`
- Combinational outputs:
  - `in_ready = (state != FULL)`
  - `out_valid = (state != EMPTY)`
  - `level` = 0 / 1 / 2 for EMPTY / ONE / FULL.
  - `out_data = rd_sel ? bank1 : bank0`, implemented by the `mux2` instance.
- On `push`: write `in_data` into the bank selected by `wr_sel`, then toggle `wr_sel`.
- On `pop`: toggle `rd_sel`.
- FSM transitions:
  - EMPTY: push → ONE; otherwise stay. A pop is impossible because `out_valid` = 0.
  - ONE: push only → FULL; pop only → EMPTY; push and pop together → stay ONE, and both selects toggle.
  - FULL: pop → ONE; a push is impossible because `in_ready` = 0.
- No bypass: data written in cycle N is first visible on `out_data` in cycle N+1.
- No combinational path from `out_ready` to `in_ready`. When FULL, a simultaneous pop does not enable a push in the same cycle.
- Order is strictly FIFO. With wrap-around, `wr_sel` and `rd_sel` toggle indefinitely, and the bank alternation is invisible to the consumer.
- `out_data` when `out_valid` = 0 is the stale selected bank. The consumer must ignore it. It must never be X after reset.
- Reset has priority over `push` and `pop` in the same cycle. Any stored data is discarded.

## Timing
- Reset values for every output:
  - `in_ready` = 1
  - `out_valid` = 0
  - `out_data` = 4'h0
  - `level` = 0
- Reset internal state: `state` = EMPTY, `wr_sel` = `rd_sel` = 0, both banks = 0.
- Latency: 1 cycle from accepted input to `out_valid`.
- Throughput: 1 nibble/cycle sustained when ONE with `in_valid` = `out_ready` = 1.
- Outputs depend only on registered state. The only combinational path is through `mux2` (register → output).
- Reset applied mid-operation: on the next edge, outputs return to their reset values regardless of `push`/`pop`.

## Structure
- Shared package `pingpong_pkg`:
  - `typedef enum logic [1:0] {EMPTY, ONE, FULL} pp_state_t;`
  - `localparam int NIBBLE_W = 4;`
- One sub-module: an instance of the existing `mux2`.
  - `d0 = bank0`, `d1 = bank1`, `s = rd_sel`, `y = out_data`.
- Everything else goes in a single `always_ff` (state, banks, selects) plus `assign`s for the handshake outputs.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `in_valid` = 1, `in_data` = 4'hF → `in_ready` = 1, `out_valid` = 0, `out_data` = 4'h0, `level` = 0; nothing stored.
- **Fill and drain:** `out_ready` = 0; push 4'h3 then 4'hA → `level` 1 then 2, `in_ready` drops after the second push. Raise `out_ready` → outputs 4'h3 then 4'hA, `out_valid` then falls.
- **Full stall:** while FULL, hold `in_valid` = 1 with `in_data` = 4'h7 and pulse `out_ready` for one cycle → exactly one pop and no push that cycle; 4'h7 is accepted on the following cycle.
- **Streaming wrap-around:** 10 back-to-back pushes of 4'h0–4'h9 with `out_ready` = 1 → same sequence out, 1 per cycle after a 1-cycle latency. `level` stays 1; `rd_sel`/`wr_sel` toggle every cycle.
- **Backpressure randomised:** 200 nibbles with random `in_valid`/`out_ready` → scoreboard shows the exact in-order match, with no drop or duplicate.
- **Mid-operation reset:** FULL with 4'h5, 4'h6; assert `reset` during a pop → next cycle EMPTY, `out_data` = 4'h0; a subsequent push of 4'hC emerges first.
